seq_detect_ctrl: RTL

//  Window-based controller for serial pattern detection. On start it latches a 4-bit pattern and an

---
 rtl/seq_detect_ctrl_pkg.sv | 22 ++
 rtl/seq_detect_ctrl_core.sv | 51 +++++
 rtl/seq_detect_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the windowed serial pattern detector.
// Holds the FSM state encoding, the pattern width and a helper that
// sizes counters from the window length.
package seq_det_pkg;

  localparam int PAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Smallest bit width able to represent the values 0 .. n-1 (minimum 1).
  function automatic int width_for(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_core.sv
// pattern_match_core: serial history of the most recent bits, a saturating
// count of how many valid history bits exist, and the match compare.
// hit is combinational and is only asserted while shift_en is high, so the
// controller sees the match on the same edge that consumes the bit.
// Only the three newest bits are kept: the fourth bit of a candidate match
// is always the incoming w, so an older bit could never take part.
module pattern_match_core
  import seq_det_pkg::*;
(
  input  logic             clk,
  input  logic             rs,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             w,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [2:0]       len_q, len_d;

  // Match when three prior bits are available and they plus w equal the pattern.
  always_comb begin
    hit = shift_en && (len_q >= 3'd3) && ({hist_q, w} == pattern);
  end

  // Next history: clear wins over shift; the length saturates at a full pattern.
  always_comb begin
    hist_d = hist_q;
    len_d  = len_q;
    if (clr) begin
      hist_d = '0;
      len_d  = '0;
    end else if (shift_en) begin
      hist_d = {hist_q[PAT_W-3:0], w};
      if (len_q < 3'(PAT_W)) len_d = len_q + 3'd1;
    end
  end

  // History registers.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      hist_q <= '0;
      len_q  <= '0;
    end else begin
      hist_q <= hist_d;
      len_q  <= len_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: arms a detection window on start, consumes WIN valid serial
// bits, pulses y on each pattern match, counts matches (saturating) and
// pulses done with the final count when the window completes.
// Optional feature macro: SEQ_DET_FIRSTPOS_EN adds the first_pos output,
// the bit index of the last bit of the first match in the window.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int WIN   = 16,
  parameter int CNT_W = width_for(WIN + 1),
  parameter int POS_W = width_for(WIN)
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap_en,
  input  logic             w,
  input  logic             w_valid,
  output logic             busy,
  output logic             y,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
`ifdef SEQ_DET_FIRSTPOS_EN
  ,
  output logic [POS_W-1:0] first_pos
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [POS_W-1:0] LAST_BIT = POS_W'(WIN - 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic [POS_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;

  logic start_acc;
  logic shift_en;
  logic clr;
  logic hit;

  // A start is taken only from IDLE and only when abort is not also asserted.
  assign start_acc = (state_q == IDLE) && start && !abort;
  // A bit is consumed only while running and not being aborted.
  assign shift_en  = (state_q == RUN) && w_valid && !abort;
  // History restarts on a new window, and after a match when overlaps are not wanted.
  assign clr       = start_acc || (hit && !ovl_q);

  pattern_match_core u_core (
    .clk      (clk),
    .rs       (rs),
    .shift_en (shift_en),
    .clr      (clr),
    .w        (w),
    .pattern  (pat_q),
    .hit      (hit)
  );

  // Next-state and datapath updates for the window controller.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    ovl_d     = ovl_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    y_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d   = RUN;
          pat_d     = pattern;
          ovl_d     = overlap_en;
          bit_cnt_d = '0;
          cnt_d     = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (shift_en) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (hit) begin
            y_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          end
          if (bit_cnt_q == LAST_BIT) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller registers; everything returns to its idle value on reset.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      ovl_q     <= 1'b0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      y_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      ovl_q     <= ovl_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
    end
  end

`ifdef SEQ_DET_FIRSTPOS_EN
  logic [POS_W-1:0] fp_q, fp_d;

  // Capture the bit index of the first match; a zero count marks "no match yet".
  always_comb begin
    fp_d = fp_q;
    if (start_acc) begin
      fp_d = '0;
    end else if (hit && (cnt_q == '0)) begin
      fp_d = bit_cnt_q;
    end
  end

  // First-match position register, held until the next start.
  always_ff @(posedge clk or negedge rs) begin
    if (!rs) begin
      fp_q <= '0;
    end else begin
      fp_q <= fp_d;
    end
  end

  assign first_pos = fp_q;
`endif

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign y         = y_q;
  assign match_cnt = cnt_q;

endmodule
